wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 77 +++++++
 tb/tb_wb_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone arbiter with bus lock held while the owner keeps cyc high
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  output logic [1:0]            gnt_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, nxt;
  logic last_gnt;
  logic own0, own1, live0, live1;
  always_comb begin
    nxt = state == GNT0 ? (m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE)
        : state == GNT1 ? (m1_cyc_i ? GNT1 : m0_cyc_i ? GNT0 : IDLE)
        : (m0_cyc_i && (!m1_cyc_i || last_gnt)) ? GNT0
        : m1_cyc_i ? GNT1 : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt_o    <= 2'b00;
    end else begin
      state <= nxt;
      gnt_o <= {nxt == GNT1, nxt == GNT0};
      if (nxt != IDLE) last_gnt <= nxt == GNT1;
    end
  end
  always_comb begin
    own0     = state == GNT0;
    own1     = state == GNT1;
    live0    = own0 && !rst_i;
    live1    = own1 && !rst_i;
    s_cyc_o  = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
    s_stb_o  = own0 ? m0_stb_i : own1 ? m1_stb_i : 1'b0;
    s_we_o   = own0 ? m0_we_i  : own1 ? m1_we_i  : 1'b0;
    s_adr_o  = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
    s_dat_o  = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
    s_sel_o  = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
    m0_ack_o = live0 && s_ack_i;
    m0_err_o = live0 && s_err_i;
    m0_dat_o = live0 ? s_dat_i : '0;
    m1_ack_o = live1 && s_ack_i;
    m1_err_o = live1 && s_err_i;
    m1_dat_o = live1 ? s_dat_i : '0;
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: scoreboard bench for wb_rr_arbiter with directed master traffic and a reactive slave
module tb_wb_rr_arbiter;
  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [15:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdat;
  } txn_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [15:0] m0_adr_i = '0;
  logic [31:0] m0_dat_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [15:0] m1_adr_i = '0;
  logic [31:0] m1_dat_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic s_ack_i, s_err_i;
  logic [1:0] gnt_o;
  logic slv_hold = 0, force_ack = 0;
  logic [1:0] prev_gnt = 2'b00;
  int compared = 0, mismatched = 0;
  txn_t tq[$];
  logic [1:0] gq[$];

  always #5 clk = ~clk;

  wb_rr_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rd_of(input logic [15:0] adr);
    return adr == 16'hBAD0 ? 32'hCAFEF00D : {16'hA5A5, adr};
  endfunction

  function automatic void push_t(input logic [1:0] gnt, input logic we, input logic [15:0] adr,
                                 input logic [31:0] wdat, input logic [3:0] sel);
    txn_t t;
    t.gnt = gnt; t.we = we; t.adr = adr; t.wdat = wdat; t.sel = sel;
    t.err = adr == 16'hBAD0;
    t.rdat = rd_of(adr);
    tq.push_back(t);
  endfunction

  initial begin
    s_ack_i = 0; s_err_i = 0; s_dat_i = '0;
    forever begin
      @(posedge clk);
      if (force_ack) begin
        s_ack_i = 1; s_err_i = 0;
      end else if (!slv_hold && s_cyc_o && s_stb_o && !s_ack_i && !s_err_i) begin
        s_err_i = s_adr_o == 16'hBAD0;
        s_ack_i = s_adr_o != 16'hBAD0;
        s_dat_i = rd_of(s_adr_o);
      end else begin
        s_ack_i = 0; s_err_i = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic own1;
    chk("gnt_legal", gnt_o == 2'b11, 0);
    chk("s_cyc_follow", s_cyc_o, gnt_o[0] ? m0_cyc_i : gnt_o[1] ? m1_cyc_i : 1'b0);
    chk("s_stb_follow", s_stb_o, gnt_o[0] ? m0_stb_i : gnt_o[1] ? m1_stb_i : 1'b0);
    chk("m0_ack_route", m0_ack_o, gnt_o[0] & s_ack_i & !rst_i);
    chk("m1_ack_route", m1_ack_o, gnt_o[1] & s_ack_i & !rst_i);
    chk("m0_err_route", m0_err_o, gnt_o[0] & s_err_i & !rst_i);
    chk("m1_err_route", m1_err_o, gnt_o[1] & s_err_i & !rst_i);
    if (gnt_o != prev_gnt && gnt_o != 2'b00) begin
      if (gq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL grant_order: got unexpected grant %b, expected none", gnt_o);
      end else chk("grant_order", gnt_o, gq.pop_front());
    end
    prev_gnt = gnt_o;
    if (!rst_i && (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o)) begin
      if (tq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_term: got termination with gnt %b, expected none", gnt_o);
      end else begin
        txn_t t;
        t = tq.pop_front();
        own1 = t.gnt[1];
        chk("txn_owner", gnt_o, t.gnt);
        chk("txn_we", s_we_o, t.we);
        chk("txn_adr", s_adr_o, t.adr);
        chk("txn_sel", s_sel_o, t.sel);
        if (t.we) chk("txn_wdat", s_dat_o, t.wdat);
        chk("txn_ack", own1 ? m1_ack_o : m0_ack_o, !t.err);
        chk("txn_err", own1 ? m1_err_o : m0_err_o, t.err);
        chk("txn_rdat", own1 ? m1_dat_o : m0_dat_o, t.rdat);
        chk("txn_other_ack", own1 ? m0_ack_o : m1_ack_o, 0);
        chk("txn_other_err", own1 ? m0_err_o : m1_err_o, 0);
        chk("txn_other_dat", own1 ? m0_dat_o : m1_dat_o, 0);
      end
    end
  end

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (n == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic xfer(input int n, input logic we, input logic [15:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit keep);
    int cnt = 0;
    bit got = 0;
    set_m(n, 1, 1, we, adr, dat, sel);
    while (!got && cnt < 300) begin
      @(negedge clk);
      cnt++;
      got = n == 0 ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
    end
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL xfer_timeout: master %0d got no termination, expected one within 300 cycles", n);
    end
    @(posedge clk); #1;
    set_m(n, keep, 0, we, adr, dat, sel);
  endtask

  task automatic do_reset;
    rst_i = 1; force_ack = 0; slv_hold = 0;
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_m_ack", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("rst_m_dat", {m0_dat_o, m1_dat_o}, 0);
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    do_reset();
    gq.push_back(2'b01);
    push_t(2'b01, 1, 16'h1234, 32'hDEADBEEF, 4'hF);
    fork
      xfer(0, 1, 16'h1234, 32'hDEADBEEF, 4'hF, 0);
      begin
        @(negedge clk); chk("lat_k_gnt", gnt_o, 2'b00);
        @(negedge clk); chk("lat_k1_gnt", gnt_o, 2'b01); chk("lat_k1_cyc", s_cyc_o, 1);
      end
    join
    repeat (2) @(posedge clk); #1;

    do_reset();
    gq.push_back(2'b01); gq.push_back(2'b10);
    push_t(2'b01, 1, 16'h0010, 32'h11111111, 4'h1);
    push_t(2'b10, 0, 16'h0020, 32'h0, 4'h8);
    fork
      xfer(0, 1, 16'h0010, 32'h11111111, 4'h1, 0);
      xfer(1, 0, 16'h0020, 32'h0, 4'h8, 0);
      begin
        logic [1:0] last = 2'b00;
        int cnt = 0;
        while (gnt_o != 2'b10 && cnt < 50) begin
          last = gnt_o;
          @(negedge clk);
          cnt++;
        end
        chk("handover_no_idle", last, 2'b01);
      end
    join
    repeat (2) @(posedge clk); #1;

    do_reset();
    for (int i = 0; i < 4; i++) begin
      gq.push_back(2'b01); gq.push_back(2'b10);
      push_t(2'b01, 1, 16'h0100 + 16'(i), 32'h1000 + 32'(i), 4'h3);
      push_t(2'b10, 0, 16'h0200 + 16'(i), 32'h0, 4'hC);
    end
    fork
      for (int i = 0; i < 4; i++) begin
        xfer(0, 1, 16'h0100 + 16'(i), 32'h1000 + 32'(i), 4'h3, 0);
        @(posedge clk); #1;
      end
      for (int j = 0; j < 4; j++) begin
        xfer(1, 0, 16'h0200 + 16'(j), 32'h0, 4'hC, 0);
        @(posedge clk); #1;
      end
    join
    repeat (2) @(posedge clk); #1;

    do_reset();
    gq.push_back(2'b10);
    push_t(2'b10, 0, 16'hBAD0, 32'h0, 4'hF);
    xfer(1, 0, 16'hBAD0, 32'h0, 4'hF, 0);
    repeat (2) @(posedge clk); #1;

    do_reset();
    gq.push_back(2'b01); gq.push_back(2'b10);
    for (int i = 0; i < 3; i++) push_t(2'b01, 0, 16'h0500 + 16'(i), 32'h0, 4'hF);
    push_t(2'b10, 1, 16'h0600, 32'h66666666, 4'h6);
    fork
      begin
        xfer(0, 0, 16'h0500, 32'h0, 4'hF, 1);
        xfer(0, 0, 16'h0501, 32'h0, 4'hF, 1);
        xfer(0, 0, 16'h0502, 32'h0, 4'hF, 0);
      end
      xfer(1, 1, 16'h0600, 32'h66666666, 4'h6, 0);
    join
    repeat (2) @(posedge clk); #1;

    do_reset();
    slv_hold = 1;
    gq.push_back(2'b10);
    set_m(1, 1, 1, 0, 16'h0300, 32'h0, 4'hF);
    repeat (2) @(posedge clk); #1;
    force_ack = 1;
    @(posedge clk); #1;
    rst_i = 1;
    @(negedge clk);
    chk("rst_mid_s_ack", s_ack_i, 1);
    chk("rst_mid_m1_ack", m1_ack_o, 0);
    chk("rst_mid_m0_ack", m0_ack_o, 0);
    @(posedge clk); #1;
    rst_i = 0; force_ack = 0; slv_hold = 0;
    gq.push_back(2'b01); gq.push_back(2'b10);
    push_t(2'b01, 1, 16'h0400, 32'h44444444, 4'hF);
    push_t(2'b10, 0, 16'h0300, 32'h0, 4'hF);
    fork
      xfer(0, 1, 16'h0400, 32'h44444444, 4'hF, 0);
      xfer(1, 0, 16'h0300, 32'h0, 4'hF, 0);
      begin
        @(negedge clk);
        chk("post_rst_gnt", gnt_o, 2'b00);
        chk("post_rst_s_cyc", s_cyc_o, 0);
      end
    join
    repeat (3) @(posedge clk);
    chk("txn_queue_drained", tq.size(), 0);
    chk("grant_queue_drained", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
